// File: rtl/io_bus_master.sv
// rtl/io_bus_master.sv - single-request initiator for the shared peripheral I/O bus
module io_bus_master #(
    parameter int CPU_WIDTH   = 16,
    parameter int DEV_BITS    = 2,
    parameter logic [(2**DEV_BITS)-1:0] DEV_MASK = {(2**DEV_BITS){1'b1}},
    parameter int WAIT_CYCLES = 0,
    localparam int NUM_DEV    = 2**DEV_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 we,
    input  logic [CPU_WIDTH-1:0] req_addr,
    input  logic [CPU_WIDTH-1:0] wdata,
    output logic                 ready,
    output logic                 done,
    output logic                 err,
    output logic [CPU_WIDTH-1:0] rdata,
    output logic [NUM_DEV-1:0]   EN,
    output logic [CPU_WIDTH-1:0] addr,
    inout  wire  [CPU_WIDTH-1:0] data,
    output logic                 ctrl
);

    localparam logic IO_CTRL_READ  = 1'b0;
    localparam logic IO_CTRL_WRITE = 1'b1;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic [NUM_DEV-1:0] EN_ONE = NUM_DEV'(1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t               state_q, state_d;
    logic                 we_q;
    logic                 drive_q;
    logic [3:0]           cnt_q;
    logic [CPU_WIDTH-1:0] wdata_q;
    logic [DEV_BITS-1:0]  dev;
    logic                 present;

    assign dev     = addr[CPU_WIDTH-1 -: DEV_BITS];
    assign present = DEV_MASK[dev];

    // Only the master's registered enable can put data on the bus, so reset releases it at once.
    assign data = drive_q ? wdata_q : {CPU_WIDTH{1'bz}};

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (req) state_d = SETUP;
            end
            SETUP:   state_d = present ? ACCESS : DONE;
            ACCESS:  if (cnt_q == WAIT_LAST) state_d = DONE;
            DONE: begin
                done    = 1'b1;
                err     = ~present;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            drive_q <= 1'b0;
            cnt_q   <= 4'd0;
            wdata_q <= '0;
            addr    <= '0;
            ctrl    <= IO_CTRL_READ;
            EN      <= '0;
            rdata   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (req) begin
                    we_q    <= we;
                    wdata_q <= wdata;
                    addr    <= req_addr;
                    ctrl    <= we ? IO_CTRL_WRITE : IO_CTRL_READ;
                    drive_q <= we;
                end
                SETUP: if (present) begin
                    EN    <= EN_ONE << dev;
                    cnt_q <= 4'd0;
                end else begin
                    drive_q <= 1'b0;
                    ctrl    <= IO_CTRL_READ;
                    if (!we_q) rdata <= '0;
                end
                ACCESS: if (cnt_q == WAIT_LAST) begin
                    EN      <= '0;
                    drive_q <= 1'b0;
                    ctrl    <= IO_CTRL_READ;
                    if (!we_q) rdata <= data;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_master.sv
// tb/tb_io_bus_master.sv - scoreboard bench for io_bus_master (zero-wait and three-wait builds)
module tb_io_bus_master;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req0, we0, req1, we1;
    logic [15:0] req_addr0, wdata0, req_addr1, wdata1;
    logic        ready0, done0, err0, ctrl0, ready1, done1, err1, ctrl1;
    logic [15:0] rdata0, addr0, rdata1, addr1;
    logic [3:0]  en0, en1;
    wire  [15:0] data0, data1;
    logic [15:0] resp_val, resp_k;

    io_bus_master #(.CPU_WIDTH(16), .DEV_BITS(2), .DEV_MASK(4'b0111), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .req_addr(req_addr0), .wdata(wdata0),
        .ready(ready0), .done(done0), .err(err0), .rdata(rdata0), .EN(en0), .addr(addr0),
        .data(data0), .ctrl(ctrl0));

    io_bus_master #(.CPU_WIDTH(16), .DEV_BITS(2), .DEV_MASK(4'b1111), .WAIT_CYCLES(3)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .we(we1), .req_addr(req_addr1), .wdata(wdata1),
        .ready(ready1), .done(done1), .err(err1), .rdata(rdata1), .EN(en1), .addr(addr1),
        .data(data1), .ctrl(ctrl1));

    // Responders: dev1/dev2 on u0 return constants; dev0 on u1 returns a value that changes each grant cycle.
    assign data0 = (en0[1] && !ctrl0) ? 16'hBEEF :
                   (en0[2] && !ctrl0) ? 16'h2222 : 16'hzzzz;
    assign data1 = (en1[0] && !ctrl1) ? resp_val : 16'hzzzz;

    always @(negedge clk) begin
        if (en1[0]) begin
            resp_val <= 16'h1000 + resp_k;
            resp_k   <= resp_k + 16'd1;
        end else begin
            resp_k <= 16'd0;
        end
    end

    typedef struct {
        int          inst;
        int          lat;
        logic        err;
        logic        chk_rd;
        logic [15:0] rd;
        logic [3:0]  en;
        int          en_cyc;
    } exp_t;

    exp_t sb[$];
    int   acc_log[$];
    int   n_chk = 0, n_err = 0, cyc = 0, done_cnt = 0;
    bit   busy[2];
    int   acc[2], hits[2], bad[2], rbad[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mon(input int i, input logic rdy, input logic rq, input logic dn,
                       input logic er, input logic [15:0] rd, input logic [3:0] e);
        exp_t x;
        if (busy[i]) begin
            if (rdy) rbad[i]++;
            if (dn) begin
                done_cnt++;
                busy[i] = 1'b0;
                if (e != 4'd0) bad[i]++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    x = sb.pop_front();
                    chk("done_inst", i, x.inst);
                    chk("latency", cyc - acc[i] + 1, x.lat);
                    chk("err", er, x.err);
                    if (x.chk_rd) chk("rdata", rd, x.rd);
                    chk("en_cycles", hits[i], x.en_cyc);
                    chk("en_wrong", bad[i], 0);
                    chk("ready_during_xfer", rbad[i], 0);
                end
            end else if (e != 4'd0) begin
                if (sb.size() != 0 && e == sb[0].en) hits[i]++;
                else bad[i]++;
            end
        end else begin
            if (dn) begin
                done_cnt++;
                chk("unexpected_done", 1, 0);
            end
            if (e != 4'd0) chk("en_while_idle", e, 0);
            if (rdy && rq) begin
                busy[i] = 1'b1;
                acc[i]  = cyc + 1;
                hits[i] = 0;
                bad[i]  = 0;
                rbad[i] = 0;
                acc_log.push_back(cyc + 1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            busy[0] = 1'b0;
            busy[1] = 1'b0;
        end else begin
            mon(0, ready0, req0, done0, err0, rdata0, en0);
            mon(1, ready1, req1, done1, err1, rdata1, en1);
        end
    end

    task automatic set_in(input int i, input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        if (i == 0) begin req0 = r; we0 = w; req_addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; req_addr1 = a; wdata1 = d; end
    endtask

    // Returns at accept edge + 1ns, i.e. in the SETUP cycle.
    task automatic issue(input int i, input logic w, input logic [15:0] a, input logic [15:0] d, input bit hold);
        bit ok = 1'b0;
        @(posedge clk); #1;
        set_in(i, 1'b1, w, a, d);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            if (busy[i]) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", 1, 0);
        #1;
        if (!hold) set_in(i, 1'b0, w, a, d);
    endtask

    task automatic wait_idle(input int i);
        bit ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (!busy[i]) begin ok = 1'b1; break; end
        end
        if (!ok) chk("done_timeout", 1, 0);
    endtask

    function automatic exp_t mk(input int i, input int lat, input logic e, input logic c,
                                input logic [15:0] rd, input logic [3:0] en, input int n);
        exp_t x;
        x.inst = i; x.lat = lat; x.err = e; x.chk_rd = c; x.rd = rd; x.en = en; x.en_cyc = n;
        return x;
    endfunction

    initial begin
        int n0, d0;
        bit ok;
        rst_n = 1'b0;
        resp_val = 16'd0;
        set_in(0, 1'b0, 1'b0, 16'd0, 16'd0);
        set_in(1, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", ready0, 1);
        chk("rst_done", done0, 0);
        chk("rst_err", err0, 0);
        chk("rst_rdata", rdata0, 16'h0);
        chk("rst_en", en0, 4'h0);
        chk("rst_addr", addr0, 16'h0);
        chk("rst_ctrl", ctrl0, 0);

        sb.push_back(mk(0, 3, 1'b0, 1'b0, 16'h0, 4'b0010, 1));
        issue(0, 1'b1, 16'h4002, 16'h00FF, 1'b0);
        chk("wr_setup_ctrl", ctrl0, 1);
        chk("wr_setup_data", data0, 16'h00FF);
        chk("wr_setup_en", en0, 4'h0);
        chk("wr_setup_addr", addr0, 16'h4002);
        wait_idle(0);

        sb.push_back(mk(0, 3, 1'b0, 1'b1, 16'hBEEF, 4'b0010, 1));
        issue(0, 1'b0, 16'h4010, 16'h0000, 1'b0);
        chk("rd_setup_ctrl", ctrl0, 0);
        wait_idle(0);

        sb.push_back(mk(0, 2, 1'b1, 1'b1, 16'hBEEF, 4'b0000, 0));
        issue(0, 1'b1, 16'hC004, 16'h1234, 1'b0);
        wait_idle(0);

        sb.push_back(mk(0, 2, 1'b1, 1'b1, 16'h0000, 4'b0000, 0));
        issue(0, 1'b0, 16'hC000, 16'h0000, 1'b0);
        wait_idle(0);

        sb.push_back(mk(1, 6, 1'b0, 1'b1, 16'h1003, 4'b0001, 4));
        issue(1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        wait_idle(1);

        sb.push_back(mk(1, 6, 1'b0, 1'b0, 16'h0, 4'b0100, 4));
        issue(1, 1'b1, 16'h8000, 16'h5A5A, 1'b0);
        chk("wr3_setup_data", data1, 16'h5A5A);
        wait_idle(1);

        n0 = acc_log.size();
        sb.push_back(mk(0, 3, 1'b0, 1'b0, 16'h0, 4'b0001, 1));
        sb.push_back(mk(0, 3, 1'b0, 1'b1, 16'h2222, 4'b0100, 1));
        issue(0, 1'b1, 16'h0001, 16'h1111, 1'b1);
        set_in(0, 1'b1, 1'b0, 16'h8004, 16'h0000);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            if (acc_log.size() >= n0 + 2) begin ok = 1'b1; break; end
        end
        if (!ok) chk("b2b_accept_timeout", 1, 0);
        #1 set_in(0, 1'b0, 1'b0, 16'h8004, 16'h0000);
        if (ok) chk("b2b_spacing", acc_log[n0+1] - acc_log[n0], 4);
        wait_idle(0);

        issue(0, 1'b1, 16'h4000, 16'hAAAA, 1'b0);
        @(posedge clk); #1;
        chk("abort_en_before", en0, 4'b0010);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort_en", en0, 4'h0);
        chk("abort_ready", ready0, 1);
        chk("abort_done", done0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_idle_ready", ready0, 1);

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
